// File: rtl/lsu_dcache_req_dispatch_pkg.sv
// Shared definitions for the LSU-to-dcache request path: default widths,
// the per-lane request payload and the dispatcher occupancy state.
package lsu_dcache_req_dispatch_pkg;

  localparam int unsigned LSU_NUM_REQS   = 4;
  localparam int unsigned LSU_WORD_SIZE  = 4;
  localparam int unsigned LSU_ADDR_WIDTH = 30;
  localparam int unsigned LSU_TAG_WIDTH  = 8;
  localparam int unsigned LSU_PERF_WIDTH = 32;

  typedef struct packed {
    logic [LSU_WORD_SIZE-1:0]   byteen;
    logic [LSU_ADDR_WIDTH-1:0]  addr;
    logic [8*LSU_WORD_SIZE-1:0] data;
  } lane_payload_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } busy_state_t;

endpackage

// File: rtl/lsu_dcache_req_dispatch_sat.sv
// Saturating up-counter with async active-low reset, used for stall
// accounting; sticks at all-ones instead of wrapping.
module lsu_sat_counter
  import lsu_dcache_req_dispatch_pkg::*;
#(
  parameter int unsigned WIDTH = LSU_PERF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/lsu_dcache_req_dispatch.sv
// Holds one warp-wide memory request and presents it to the dcache lanes,
// retiring lanes independently and pulsing done once every active lane is taken.
module lsu_dcache_req_dispatch
  import lsu_dcache_req_dispatch_pkg::*;
#(
  parameter int unsigned NUM_REQS   = LSU_NUM_REQS,
  parameter int unsigned WORD_SIZE  = LSU_WORD_SIZE,
  parameter int unsigned ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int unsigned TAG_WIDTH  = LSU_TAG_WIDTH,
  parameter int unsigned PERF_WIDTH = LSU_PERF_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  input  logic [NUM_REQS-1:0]               in_mask,
  input  logic                              in_rw,
  input  logic [NUM_REQS*WORD_SIZE-1:0]     in_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]    in_addr,
  input  logic [NUM_REQS*8*WORD_SIZE-1:0]   in_data,
  input  logic [TAG_WIDTH-1:0]              in_tag,
  output logic                              in_ready,
  output logic [NUM_REQS-1:0]               dc_valid,
  output logic [NUM_REQS-1:0]               dc_rw,
  output logic [NUM_REQS*WORD_SIZE-1:0]     dc_byteen,
  output logic [NUM_REQS*ADDR_WIDTH-1:0]    dc_addr,
  output logic [NUM_REQS*8*WORD_SIZE-1:0]   dc_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0]     dc_tag,
  input  logic [NUM_REQS-1:0]               dc_ready,
  output logic                              done_valid,
  output logic [TAG_WIDTH-1:0]              done_tag,
  output logic [PERF_WIDTH-1:0]             perf_stall_cycles
);

  busy_state_t                       state_q;
  logic [NUM_REQS-1:0]               pending_q;
  logic                              rw_q;
  logic [NUM_REQS*WORD_SIZE-1:0]     byteen_q;
  logic [NUM_REQS*ADDR_WIDTH-1:0]    addr_q;
  logic [NUM_REQS*8*WORD_SIZE-1:0]   data_q;
  logic [TAG_WIDTH-1:0]              tag_q;

  logic                              busy;
  logic [NUM_REQS-1:0]               fire;
  logic                              last_fire;
  logic                              accept;
  logic                              stall;

  assign busy      = (state_q == ST_BUSY);
  assign dc_valid  = busy ? pending_q : '0;
  assign fire      = dc_valid & dc_ready;
  assign last_fire = busy && ((pending_q & ~fire) == '0);
  assign in_ready  = !busy || last_fire;
  assign accept    = in_valid && in_ready;
  // pending is only empty while busy when a zero-mask request is parked behind a retiring one
  assign stall     = busy && (fire == '0) && (pending_q != '0);

  assign dc_rw     = {NUM_REQS{rw_q}};
  assign dc_tag    = {NUM_REQS{tag_q}};
  assign dc_byteen = byteen_q;
  assign dc_addr   = addr_q;
  assign dc_data   = data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      rw_q       <= 1'b0;
      byteen_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      done_valid <= 1'b0;
      done_tag   <= '0;
    end else begin
      done_valid <= 1'b0;

      if (last_fire) begin
        done_valid <= 1'b1;
        done_tag   <= tag_q;
        state_q    <= ST_IDLE;
        pending_q  <= '0;
      end else if (busy) begin
        pending_q  <= pending_q & ~fire;
      end

      if (accept) begin
        if (in_mask != '0) begin
          state_q   <= ST_BUSY;
          pending_q <= in_mask;
          rw_q      <= in_rw;
          byteen_q  <= in_byteen;
          addr_q    <= in_addr;
          data_q    <= in_data;
          tag_q     <= in_tag;
        end else if (last_fire) begin
          // done slot is taken by the retiring request: park the empty one
          // as busy with no lanes so it retires (and pulses) next cycle
          state_q   <= ST_BUSY;
          tag_q     <= in_tag;
        end else begin
          done_valid <= 1'b1;
          done_tag   <= in_tag;
        end
      end
    end
  end

  lsu_sat_counter #(
    .WIDTH (PERF_WIDTH)
  ) u_stall_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall),
    .count   (perf_stall_cycles)
  );

endmodule

// File: tb/tb_lsu_dcache_req_dispatch.sv
// Directed bench for lsu_dcache_req_dispatch with a done-tag scoreboard;
// a second instance with a 4-bit stall counter exercises saturation.
module tb_lsu_dcache_req_dispatch;
  import lsu_dcache_req_dispatch_pkg::*;

  localparam int N  = 4;
  localparam int WS = 4;
  localparam int AW = 30;
  localparam int TW = 8;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 in_valid;
  logic [N-1:0]         in_mask;
  logic                 in_rw;
  logic [N*WS-1:0]      in_byteen;
  logic [N*AW-1:0]      in_addr;
  logic [N*8*WS-1:0]    in_data;
  logic [TW-1:0]        in_tag;
  logic                 in_ready;
  logic [N-1:0]         dc_valid;
  logic [N-1:0]         dc_rw;
  logic [N*WS-1:0]      dc_byteen;
  logic [N*AW-1:0]      dc_addr;
  logic [N*8*WS-1:0]    dc_data;
  logic [N*TW-1:0]      dc_tag;
  logic [N-1:0]         dc_ready;
  logic                 done_valid;
  logic [TW-1:0]        done_tag;
  logic [31:0]          perf_stall_cycles;

  logic                 p4_in_ready;
  logic [N-1:0]         p4_dc_valid;
  logic [N-1:0]         p4_dc_rw;
  logic [N*WS-1:0]      p4_dc_byteen;
  logic [N*AW-1:0]      p4_dc_addr;
  logic [N*8*WS-1:0]    p4_dc_data;
  logic [N*TW-1:0]      p4_dc_tag;
  logic                 p4_done_valid;
  logic [TW-1:0]        p4_done_tag;
  logic [3:0]           p4_perf;

  always #5 clk = ~clk;

  lsu_dcache_req_dispatch #(
    .NUM_REQS (N), .WORD_SIZE (WS), .ADDR_WIDTH (AW), .TAG_WIDTH (TW), .PERF_WIDTH (32)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .in_valid (in_valid), .in_mask (in_mask), .in_rw (in_rw), .in_byteen (in_byteen),
    .in_addr (in_addr), .in_data (in_data), .in_tag (in_tag), .in_ready (in_ready),
    .dc_valid (dc_valid), .dc_rw (dc_rw), .dc_byteen (dc_byteen), .dc_addr (dc_addr),
    .dc_data (dc_data), .dc_tag (dc_tag), .dc_ready (dc_ready),
    .done_valid (done_valid), .done_tag (done_tag), .perf_stall_cycles (perf_stall_cycles)
  );

  lsu_dcache_req_dispatch #(
    .NUM_REQS (N), .WORD_SIZE (WS), .ADDR_WIDTH (AW), .TAG_WIDTH (TW), .PERF_WIDTH (4)
  ) dut_p4 (
    .clk (clk), .reset_n (reset_n),
    .in_valid (in_valid), .in_mask (in_mask), .in_rw (in_rw), .in_byteen (in_byteen),
    .in_addr (in_addr), .in_data (in_data), .in_tag (in_tag), .in_ready (p4_in_ready),
    .dc_valid (p4_dc_valid), .dc_rw (p4_dc_rw), .dc_byteen (p4_dc_byteen), .dc_addr (p4_dc_addr),
    .dc_data (p4_dc_data), .dc_tag (p4_dc_tag), .dc_ready (dc_ready),
    .done_valid (p4_done_valid), .done_tag (p4_done_tag), .perf_stall_cycles (p4_perf)
  );

  int unsigned   total = 0;
  int unsigned   bad   = 0;
  logic [TW-1:0] sb[$];
  logic [TW-1:0] sb_exp;
  lane_payload_t exp_lane [N];
  logic          exp_rw;
  logic [TW-1:0] exp_tag;
  int unsigned   exp_stall;
  int unsigned   exp_stall4;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [N-1:0] mask, input logic rw, input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_mask  = mask;
    in_rw    = rw;
    in_tag   = tag;
    exp_rw   = rw;
    exp_tag  = tag;
    for (int i = 0; i < N; i++) begin
      exp_lane[i].byteen = 4'(i + 1) ^ tag[3:0];
      exp_lane[i].addr   = {tag, 20'h5A5A5, 2'(i)};
      exp_lane[i].data   = {tag, 8'(i), 16'hBEEF};
      in_byteen[i*WS +: WS]  = exp_lane[i].byteen;
      in_addr[i*AW +: AW]    = exp_lane[i].addr;
      in_data[i*8*WS +: 8*WS] = exp_lane[i].data;
    end
  endtask

  task automatic check_lanes(input string name, input logic [N-1:0] exp_valid);
    chk({name, ".dc_valid"}, 64'(dc_valid), 64'(exp_valid));
    for (int i = 0; i < N; i++) begin
      if (exp_valid[i]) begin
        chk($sformatf("%s.addr%0d", name, i), 64'(dc_addr[i*AW +: AW]), 64'(exp_lane[i].addr));
        chk($sformatf("%s.data%0d", name, i), 64'(dc_data[i*8*WS +: 8*WS]), 64'(exp_lane[i].data));
        chk($sformatf("%s.byteen%0d", name, i), 64'(dc_byteen[i*WS +: WS]), 64'(exp_lane[i].byteen));
        chk($sformatf("%s.tag%0d", name, i), 64'(dc_tag[i*TW +: TW]), 64'(exp_tag));
        chk($sformatf("%s.rw%0d", name, i), 64'(dc_rw[i]), 64'(exp_rw));
      end
    end
  endtask

  task automatic add_stall(input int unsigned n);
    exp_stall  = exp_stall + n;
    exp_stall4 = (exp_stall4 + n > 15) ? 15 : exp_stall4 + n;
  endtask

  task automatic chk_stall(input string name);
    chk({name, ".stall"}, 64'(perf_stall_cycles), 64'(exp_stall));
    chk({name, ".stall4"}, 64'(p4_perf), 64'(exp_stall4));
  endtask

  task automatic chk_done(input string name, input logic exp_v, input logic [TW-1:0] exp_t);
    chk({name, ".done_valid"}, 64'(done_valid), 64'(exp_v));
    if (exp_v) chk({name, ".done_tag"}, 64'(done_tag), 64'(exp_t));
  endtask

  // scoreboard: every done pulse must match the oldest outstanding tag
  always @(negedge clk) begin
    if (done_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $error("FAIL sb.unexpected_done observed=0x%0h expected=none", done_tag);
      end else begin
        sb_exp = sb.pop_front();
        assert (done_tag === sb_exp) else begin
          bad++;
          $error("FAIL sb.done_tag observed=0x%0h expected=0x%0h", done_tag, sb_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_mask = '0; in_rw = 1'b0; in_byteen = '0;
    in_addr = '0; in_data = '0; in_tag = '0; dc_ready = '0;
    exp_stall = 0; exp_stall4 = 0; exp_rw = 1'b0; exp_tag = '0;

    repeat (2) @(negedge clk);
    chk("rst.dc_valid", 64'(dc_valid), 64'(0));
    chk("rst.done_valid", 64'(done_valid), 64'(0));
    chk("rst.done_tag", 64'(done_tag), 64'(0));
    chk_stall("rst");
    reset_n = 1'b1;
    #1 chk("rst.in_ready", 64'(in_ready), 64'(1));

    // full mask, all lanes ready immediately
    @(negedge clk);
    drive_req(4'b1111, 1'b1, 8'h3A); dc_ready = 4'b1111; sb.push_back(8'h3A);
    #1 chk("t1.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check_lanes("t1", 4'b1111);
    chk_done("t1.early", 1'b0, '0);
    @(negedge clk);
    chk_done("t1", 1'b1, 8'h3A);
    chk("t1.dc_valid_after", 64'(dc_valid), 64'(0));
    chk_stall("t1");

    // partial lane acceptance
    @(negedge clk);
    drive_req(4'b1011, 1'b0, 8'h5B); dc_ready = 4'b0010; sb.push_back(8'h5B);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check_lanes("t2a", 4'b1011);
    chk("t2a.in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    check_lanes("t2b", 4'b1001);
    chk_done("t2b", 1'b0, '0);
    dc_ready = 4'b1001;
    #1 chk("t2b.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    chk_done("t2", 1'b1, 8'h5B);
    chk("t2.dc_valid_after", 64'(dc_valid), 64'(0));
    chk_stall("t2");

    // single lane stalled for five cycles
    @(negedge clk);
    drive_req(4'b0001, 1'b1, 8'h6C); dc_ready = 4'b0000; sb.push_back(8'h6C);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 check_lanes($sformatf("t3.c%0d", k), 4'b0001);
      chk($sformatf("t3.c%0d.in_ready", k), 64'(in_ready), 64'(0));
      @(negedge clk);
    end
    add_stall(5);
    chk_stall("t3");
    dc_ready = 4'b0001;
    #1 chk("t3.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    chk_done("t3", 1'b1, 8'h6C);

    // back-to-back: second request accepted on the first's last fire
    @(negedge clk);
    drive_req(4'b1100, 1'b0, 8'h71); dc_ready = 4'b1111; sb.push_back(8'h71);
    @(negedge clk);
    check_lanes("t4a", 4'b1100);
    drive_req(4'b0011, 1'b1, 8'h72); sb.push_back(8'h72);
    #1 chk("t4a.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    chk_done("t4b", 1'b1, 8'h71);
    check_lanes("t4b", 4'b0011);
    @(negedge clk);
    chk_done("t4c", 1'b1, 8'h72);
    chk("t4c.dc_valid", 64'(dc_valid), 64'(0));
    @(negedge clk);
    chk_done("t4d", 1'b0, '0);
    chk_stall("t4");

    // zero mask: done without dcache traffic
    drive_req(4'b0000, 1'b0, 8'h11); sb.push_back(8'h11);
    #1 chk("t5z.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5z.dc_valid", 64'(dc_valid), 64'(0));
    chk_done("t5z", 1'b1, 8'h11);

    // twenty stall cycles: 4-bit counter saturates at 15
    @(negedge clk);
    chk_done("t5s.idle", 1'b0, '0);
    drive_req(4'b0100, 1'b1, 8'h22); dc_ready = 4'b0000; sb.push_back(8'h22);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    add_stall(20);
    chk_stall("t5s");
    check_lanes("t5s", 4'b0100);
    dc_ready = 4'b1111;
    @(negedge clk);
    chk_done("t5s", 1'b1, 8'h22);

    // asynchronous reset with lanes in flight
    @(negedge clk);
    drive_req(4'b0110, 1'b0, 8'h33); dc_ready = 4'b0000; sb.push_back(8'h33);
    @(negedge clk);
    in_valid = 1'b0;
    check_lanes("t6a", 4'b0110);
    #2 reset_n = 1'b0;
    sb.delete();
    exp_stall = 0; exp_stall4 = 0;
    #1 chk("t6r.dc_valid", 64'(dc_valid), 64'(0));
    chk("t6r.done_valid", 64'(done_valid), 64'(0));
    chk_stall("t6r");
    @(negedge clk);
    chk_done("t6r.no_done", 1'b0, '0);
    reset_n = 1'b1;
    #1 chk("t6r.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    chk_done("t6r.still_no_done", 1'b0, '0);
    drive_req(4'b1111, 1'b1, 8'h44); dc_ready = 4'b1111; sb.push_back(8'h44);
    @(negedge clk);
    in_valid = 1'b0;
    check_lanes("t6b", 4'b1111);
    @(negedge clk);
    chk_done("t6b", 1'b1, 8'h44);
    chk_stall("t6b");
    @(negedge clk);
    chk_done("t6c", 1'b0, '0);
    chk("sb.empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_dcache_req_dispatch.md
# lsu_dcache_req_dispatch

Sits between the LSU issue stage and the data cache request port; it is the upstream driver of the per-lane dcache request bundle. It accepts one warp-wide memory request (lane mask plus per-lane address/data/byte-enable, one shared tag) and holds it while the dcache accepts lanes independently on per-lane ready. It frees the entry only when every active lane has been accepted, then reports completion. A stall counter feeds performance monitoring.

## Interface
- NUM_REQS, 4, lanes per warp request / dcache request ports
- WORD_SIZE, 4, bytes per word; byteen width per lane
- ADDR_WIDTH, 30, word-address width per lane
- TAG_WIDTH, 8, request tag width, replicated to every lane
- PERF_WIDTH, 32, stall counter width
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  warp request valid
- in_mask  in  NUM_REQS  active lanes
- in_rw  in  1  1 = write, shared by all lanes
- in_byteen  in  NUM_REQS×WORD_SIZE  per-lane byte enables
- in_addr  in  NUM_REQS×ADDR_WIDTH  per-lane word address
- in_data  in  NUM_REQS×8·WORD_SIZE  per-lane write data
- in_tag  in  TAG_WIDTH  request tag
- in_ready  out  1  request accepted when in_valid & in_ready
- dc_valid  out  NUM_REQS  per-lane request valid
- dc_rw  out  NUM_REQS  per-lane rw
- dc_byteen, dc_addr, dc_data, dc_tag  out  per-lane, widths as above
- dc_ready  in  NUM_REQS  per-lane accept
- done_valid  out  1  one-cycle pulse: a warp request is fully issued
- done_tag  out  TAG_WIDTH  tag of completed request
- perf_stall_cycles  out  PERF_WIDTH  saturating stall count

## Operation
- State: busy (1 bit), pending mask (NUM_REQS), registered payload (rw, byteen, addr, data, tag).
- fire[i] = dc_valid[i] & dc_ready[i]; dc_valid = busy ? pending : 0.
- last_fire = busy & ((pending & ~fire) == 0).
- in_ready = ~busy | last_fire (combinational from dc_ready; back-to-back allowed).
- Accept with in_mask != 0: load payload, pending ← in_mask, busy ← 1.
- Accept with in_mask == 0: no dcache traffic, busy unchanged, done pulse with in_tag next cycle.
- While busy, not last_fire: pending ← pending & ~fire; payload held stable.
- last_fire without new accept: busy ← 0, pending ← 0, done pulse.
- last_fire with simultaneous accept: done pulse for old tag; new request loaded same edge; no idle cycle.
- dc_rw, dc_tag replicate registered rw/tag on all lanes; inactive lanes drive payload values but dc_valid = 0.
- dc_valid[i] never deasserts before fire[i] (no retraction); payload of a valid lane never changes before fire.
- perf_stall_cycles += 1 each cycle busy & (fire == 0); saturates at all-ones.
- Reset (async, any time): busy 0, pending 0, done_valid 0, done_tag 0, perf_stall_cycles 0, payload 0; in-flight lanes dropped, no done pulse.

## Timing
- Request accepted at edge N → dc_valid visible in cycle N+1 (one-cycle latency, registered outputs).
- Lane accepted at edge M → that dc_valid bit low from cycle M+1.
- done_valid/done_tag registered: high exactly the cycle after the edge where the last lane fires (or the zero-mask accept).
- All dcache ready in first cycle: sustained throughput one warp request per cycle.
- in_ready during reset deassertion cycle = 1 (idle).

## Structure
- Shared package: lane payload typedef (byteen, addr, data), request tag width constant, PERF_WIDTH default; reused by the dcache-side request bundle.
- One sub-module: lsu_sat_counter (PERF_WIDTH, async active-low reset, inc enable, saturate) for the stall counter.
- Remainder single always_ff block plus combinational ready/fire logic.

## Test plan
- Mask 4'b1111, dc_ready all 1 from accept: dc_valid 4'b1111 one cycle, done_valid next cycle with tag 0x3A, stall count 0.
- Mask 4'b1011, dc_ready lane1 only first cycle, then lanes 0,3: pending 4'b1001 then 0; in_ready low first cycle; done on cycle 3; stall 0.
- Mask 4'b0001, dc_ready held 0 for 5 cycles: dc_valid/addr stable, stall counter = 5, in_ready low throughout.
- Back-to-back: second request valid while first's last lane fires: accepted same edge, dc_valid shows second mask next cycle, two done pulses on consecutive cycles with correct tags.
- Mask 4'b0000 tag 0x11: no dc_valid, done pulse next cycle with 0x11; PERF_WIDTH=4 forced stall 20 cycles → counter holds 15.
- reset_n low mid-request (pending 4'b0110): outputs zero immediately, no done pulse; new request after release issues normally.
